asp_node: RTL and testbench
===========================

ASP_NODE -- requirements
Module: asp_node

Interface
REQ-001 The module SHALL have parameter data_size, default 32, payload width in bits.
REQ-002 The module SHALL have parameter tag_size, default 8, sequence-tag width in bits.
REQ-003 The module SHALL have parameter timeout_cycles, default 16, retransmit interval in clock cycles (>=2).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_parity_ready_in  input  1  host word valid, one-cycle strobe.
REQ-007 data_parity_in  input  data_size+1  bit [data_size] = parity, bits [data_size-1:0] = data.
REQ-008 network_data_ready_in  input  1  network word valid, one-cycle strobe.
REQ-009 network_ACK_in  input  1  acknowledge from network for the outstanding transmitted word.
REQ-010 network_data_tag_in  input  data_size+tag_size  bits [data_size+tag_size-1:data_size] = tag, bits [data_size-1:0] = data.
REQ-011 parity_error_out  output  1  one-cycle pulse on rejected host word.
REQ-012 host_data_ready_out  output  1  one-cycle pulse, host_data_out valid.
REQ-013 host_data_out  output  data_size  payload delivered to host; holds last value.
REQ-014 network_data_ready_out  output  1  one-cycle pulse, network_data_tag_out valid.
REQ-015 network_ACK_out  output  1  one-cycle acknowledge pulse to network.
REQ-016 network_data_tag_out  output  data_size+tag_size  {tag, data}; holds last value.

Function
REQ-017 All outputs SHALL be registered; every response SHALL appear in the cycle after the edge that samples its cause.
REQ-018 TX path SHALL be an FSM with states TX_IDLE and TX_WAIT_ACK; RX path SHALL be independent and operate concurrently with TX.
REQ-019 In TX_IDLE with data_parity_ready_in=1, parity SHALL be even: word good iff XOR of all data_size+1 input bits is 0.
REQ-020 Bad word: parity_error_out SHALL pulse one cycle, word dropped, state stays TX_IDLE, tx_tag unchanged.
REQ-021 Good word: network_data_tag_out SHALL load {tx_tag, data}, network_data_ready_out SHALL pulse one cycle, FSM enters TX_WAIT_ACK, timeout counter cleared.
REQ-022 In TX_WAIT_ACK, data_parity_ready_in SHALL be ignored (no error pulse, no send).
REQ-023 network_ACK_in=1 sampled in TX_WAIT_ACK SHALL increment tx_tag modulo 2^tag_size and return to TX_IDLE; ACK in TX_IDLE SHALL be ignored.
REQ-024 No ACK for timeout_cycles cycles after a send pulse SHALL re-pulse network_data_ready_out with identical network_data_tag_out and restart the counter; retries unlimited.
REQ-025 ACK sampled on the same edge as a timeout SHALL win (no retransmit).
REQ-026 RX: on network_data_ready_in=1 with tag == rx_tag: host_data_out loads data, host_data_ready_out and network_ACK_out pulse one cycle, rx_tag increments modulo 2^tag_size.
REQ-027 RX: tag == rx_tag-1 (mod 2^tag_size, duplicate): network_ACK_out SHALL pulse, no host delivery, rx_tag unchanged.
REQ-028 RX: any other tag SHALL be dropped silently (no pulses).
REQ-029 Tag wrap-around: tx_tag/rx_tag 2^tag_size-1 SHALL advance to 0.

Reset
REQ-030 reset=1 SHALL force all outputs to 0, tx_tag=rx_tag=0, timeout counter 0, FSM TX_IDLE; takes priority over all inputs.
REQ-031 Reset mid-transmission SHALL abandon the outstanding word with no further retransmission.

Verification
REQ-032 After reset, data_parity_in=0x0_00000001 (parity 0, odd) strobed -> parity_error_out=1 next cycle, no network_data_ready_out.
REQ-033 data_parity_in=0x1_00000001 strobed -> next cycle network_data_ready_out=1, network_data_tag_out=0x00_00000001; ACK -> next good word sent with tag 0x01.
REQ-034 Good word sent, no ACK -> network_data_ready_out re-pulses exactly 16 cycles later with same tag; ACK on timeout edge -> no re-pulse.
REQ-035 network_data_tag_in=0x00_DEADBEEF strobed after reset -> host_data_out=0xDEADBEEF, host_data_ready_out=1, network_ACK_out=1 next cycle; same word again -> ACK only; tag 0x05 -> nothing.
REQ-036 Send 256 words with ACK each -> tag wraps 0xFF to 0x00; reset asserted in TX_WAIT_ACK -> all outputs 0 next cycle, no retransmit afterward.

Source files
------------

// File: rtl/asp_node.sv
// Reliable point-to-point link node: parity-checked host words go out with a
// sequence tag and are retransmitted until acknowledged; tagged network words are delivered in order.
module asp_node #(
    parameter int data_size      = 32,
    parameter int tag_size       = 8,
    parameter int timeout_cycles = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_parity_ready_in,
    input  logic [data_size:0]            data_parity_in,
    input  logic                          network_data_ready_in,
    input  logic                          network_ACK_in,
    input  logic [data_size+tag_size-1:0] network_data_tag_in,
    output logic                          parity_error_out,
    output logic                          host_data_ready_out,
    output logic [data_size-1:0]          host_data_out,
    output logic                          network_data_ready_out,
    output logic                          network_ACK_out,
    output logic [data_size+tag_size-1:0] network_data_tag_out
);

    localparam int CNT_W = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

    localparam logic [0:0] TX_IDLE     = 1'b0;
    localparam logic [0:0] TX_WAIT_ACK = 1'b1;

    // ------------------------------------------------------------------
    // Even-parity check over all data_size+1 host bits
    // ------------------------------------------------------------------
    logic [data_size+1:0] parity_chain;
    logic                 parity_ok;

    assign parity_chain[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi <= data_size; gi = gi + 1) begin : g_parity
            assign parity_chain[gi+1] = parity_chain[gi] ^ data_parity_in[gi];
        end
    endgenerate

    assign parity_ok = ~parity_chain[data_size+1];

    // ------------------------------------------------------------------
    // TX state
    // ------------------------------------------------------------------
    logic [0:0]          tx_state_reg, tx_state_next;
    logic [tag_size-1:0] tx_tag_reg, tx_tag_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                tx_load;
    logic                tx_send;
    logic                tx_perr;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_tag_next   = tx_tag_reg;
        cnt_next      = cnt_reg;
        tx_load       = 1'b0;
        tx_send       = 1'b0;
        tx_perr       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (data_parity_ready_in) begin
                    if (parity_ok) begin
                        tx_load       = 1'b1;
                        tx_send       = 1'b1;
                        cnt_next      = '0;
                        tx_state_next = TX_WAIT_ACK;
                    end else begin
                        tx_perr = 1'b1;
                    end
                end
            end
            TX_WAIT_ACK: begin
                // An ACK arriving on the timeout edge beats the retransmit.
                if (network_ACK_in) begin
                    tx_tag_next   = tx_tag_reg + 1'b1;
                    cnt_next      = '0;
                    tx_state_next = TX_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    tx_send  = 1'b1;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
                cnt_next      = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg           <= TX_IDLE;
            tx_tag_reg             <= '0;
            cnt_reg                <= '0;
            parity_error_out       <= 1'b0;
            network_data_ready_out <= 1'b0;
            network_data_tag_out   <= '0;
        end else begin
            tx_state_reg           <= tx_state_next;
            tx_tag_reg             <= tx_tag_next;
            cnt_reg                <= cnt_next;
            parity_error_out       <= tx_perr;
            network_data_ready_out <= tx_send;
            if (tx_load) begin
                network_data_tag_out <= {tx_tag_reg, data_parity_in[data_size-1:0]};
            end
        end
    end

    // ------------------------------------------------------------------
    // RX path, independent of TX
    // ------------------------------------------------------------------
    logic [tag_size-1:0]  rx_tag_reg, rx_tag_next;
    logic [tag_size-1:0]  rx_tag_prev;
    logic [tag_size-1:0]  rx_tag_field;
    logic [data_size-1:0] rx_data_field;
    logic                 rx_fresh;
    logic                 rx_dup;

    assign rx_tag_field  = network_data_tag_in[data_size+tag_size-1:data_size];
    assign rx_data_field = network_data_tag_in[data_size-1:0];
    assign rx_tag_prev   = rx_tag_reg - 1'b1;

    always_comb begin
        rx_fresh    = 1'b0;
        rx_dup      = 1'b0;
        rx_tag_next = rx_tag_reg;
        if (network_data_ready_in) begin
            if (rx_tag_field == rx_tag_reg) begin
                rx_fresh    = 1'b1;
                rx_tag_next = rx_tag_reg + 1'b1;
            end else if (rx_tag_field == rx_tag_prev) begin
                // Sender missed our ACK: re-acknowledge without redelivering.
                rx_dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_tag_reg          <= '0;
            host_data_ready_out <= 1'b0;
            host_data_out       <= '0;
            network_ACK_out     <= 1'b0;
        end else begin
            rx_tag_reg          <= rx_tag_next;
            host_data_ready_out <= rx_fresh;
            network_ACK_out     <= rx_fresh | rx_dup;
            if (rx_fresh) begin
                host_data_out <= rx_data_field;
            end
        end
    end

endmodule

// File: tb/tb_asp_node.sv
// Directed bench for asp_node: parity reject, send/ACK, timeout retransmit,
// RX in-order/duplicate/drop, tag wrap and reset abandonment.
module tb_asp_node;

    logic        clk;
    logic        reset;
    logic        data_parity_ready_in;
    logic [32:0] data_parity_in;
    logic        network_data_ready_in;
    logic        network_ACK_in;
    logic [39:0] network_data_tag_in;
    logic        parity_error_out;
    logic        host_data_ready_out;
    logic [31:0] host_data_out;
    logic        network_data_ready_out;
    logic        network_ACK_out;
    logic [39:0] network_data_tag_out;

    int vectors;
    int miscompares;

    asp_node #(
        .data_size     (32),
        .tag_size      (8),
        .timeout_cycles(16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .data_parity_ready_in  (data_parity_ready_in),
        .data_parity_in        (data_parity_in),
        .network_data_ready_in (network_data_ready_in),
        .network_ACK_in        (network_ACK_in),
        .network_data_tag_in   (network_data_tag_in),
        .parity_error_out      (parity_error_out),
        .host_data_ready_out   (host_data_ready_out),
        .host_data_out         (host_data_out),
        .network_data_ready_out(network_data_ready_out),
        .network_ACK_out       (network_ACK_out),
        .network_data_tag_out  (network_data_tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".perr"}, 64'(parity_error_out), 64'd0);
        check({name, ".hdr"}, 64'(host_data_ready_out), 64'd0);
        check({name, ".host"}, 64'(host_data_out), 64'd0);
        check({name, ".ndr"}, 64'(network_data_ready_out), 64'd0);
        check({name, ".ack"}, 64'(network_ACK_out), 64'd0);
        check({name, ".ntag"}, 64'(network_data_tag_out), 64'd0);
    endtask

    logic [31:0] word;
    logic [7:0]  exp_tag;
    int          pulses;

    initial begin
        vectors               = 0;
        miscompares           = 0;
        reset                 = 1'b1;
        data_parity_ready_in  = 1'b0;
        data_parity_in        = '0;
        network_data_ready_in = 1'b0;
        network_ACK_in        = 1'b0;
        network_data_tag_in   = '0;

        // Reset has priority over strobed inputs
        tick();
        data_parity_ready_in  = 1'b1;
        data_parity_in        = 33'h1_00000001;
        network_data_ready_in = 1'b1;
        network_data_tag_in   = 40'h00_11111111;
        tick();
        $display("reset with inputs strobed");
        check_all_zero("reset");
        reset                 = 1'b0;
        data_parity_ready_in  = 1'b0;
        network_data_ready_in = 1'b0;

        // Odd parity word rejected
        data_parity_in       = 33'h0_00000001;
        data_parity_ready_in = 1'b1;
        tick();
        data_parity_ready_in = 1'b0;
        $display("host word 0_00000001 (odd)");
        check("bad.perr", 64'(parity_error_out), 64'd1);
        check("bad.ndr", 64'(network_data_ready_out), 64'd0);
        tick();
        check("bad.perr_drop", 64'(parity_error_out), 64'd0);

        // Good word sent with tag 0
        data_parity_in       = 33'h1_00000001;
        data_parity_ready_in = 1'b1;
        tick();
        data_parity_ready_in = 1'b0;
        $display("host word 1_00000001 (even)");
        check("send0.ndr", 64'(network_data_ready_out), 64'd1);
        check("send0.ntag", 64'(network_data_tag_out), 64'h00_00000001);

        // 15 quiet cycles, host strobes ignored in TX_WAIT_ACK
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            data_parity_ready_in = (k == 5) || (k == 7);
            data_parity_in       = (k == 5) ? 33'h1_00000002 : 33'h0_00000002;
            tick();
            if (network_data_ready_out || parity_error_out) pulses++;
        end
        data_parity_ready_in = 1'b0;
        check("wait.quiet", 64'(pulses), 64'd0);
        check("wait.ntag_hold", 64'(network_data_tag_out), 64'h00_00000001);
        tick();
        $display("timeout retransmit after 16 cycles");
        check("retx.ndr", 64'(network_data_ready_out), 64'd1);
        check("retx.ntag", 64'(network_data_tag_out), 64'h00_00000001);

        // ACK on the timeout edge suppresses the retransmit
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (network_data_ready_out) pulses++;
        end
        check("wait2.quiet", 64'(pulses), 64'd0);
        network_ACK_in = 1'b1;
        tick();
        network_ACK_in = 1'b0;
        $display("ACK on timeout edge");
        check("ackwin.ndr", 64'(network_data_ready_out), 64'd0);

        // ACK while idle must not advance tx_tag
        network_ACK_in = 1'b1;
        tick();
        network_ACK_in = 1'b0;
        check("idleack.ndr", 64'(network_data_ready_out), 64'd0);

        data_parity_in       = 33'h1_12345678;
        data_parity_ready_in = 1'b1;
        tick();
        data_parity_ready_in = 1'b0;
        $display("host word 1_12345678");
        check("send1.ndr", 64'(network_data_ready_out), 64'd1);
        check("send1.ntag", 64'(network_data_tag_out), 64'h01_12345678);
        network_ACK_in = 1'b1;
        tick();
        network_ACK_in = 1'b0;

        // RX: in-order, duplicate, out-of-window
        network_data_tag_in   = 40'h00_DEADBEEF;
        network_data_ready_in = 1'b1;
        tick();
        $display("net word 00_DEADBEEF");
        check("rx0.host", 64'(host_data_out), 64'hDEADBEEF);
        check("rx0.hdr", 64'(host_data_ready_out), 64'd1);
        check("rx0.ack", 64'(network_ACK_out), 64'd1);
        tick();
        $display("net word 00_DEADBEEF (duplicate)");
        check("dup.hdr", 64'(host_data_ready_out), 64'd0);
        check("dup.ack", 64'(network_ACK_out), 64'd1);
        check("dup.host", 64'(host_data_out), 64'hDEADBEEF);
        network_data_tag_in = 40'h05_00000BAD;
        tick();
        network_data_ready_in = 1'b0;
        $display("net word 05_00000BAD (dropped)");
        check("drop.hdr", 64'(host_data_ready_out), 64'd0);
        check("drop.ack", 64'(network_ACK_out), 64'd0);
        check("drop.host", 64'(host_data_out), 64'hDEADBEEF);

        // TX tag walk through 0xFF -> 0x00
        exp_tag = 8'h02;
        for (int i = 0; i < 256; i++) begin
            word                 = 32'(i) * 32'h9E3779B9;
            data_parity_in       = {^word, word};
            data_parity_ready_in = 1'b1;
            tick();
            data_parity_ready_in = 1'b0;
            $display("tx tag %02h data %08h", exp_tag, word);
            check("txwrap.ndr", 64'(network_data_ready_out), 64'd1);
            check("txwrap.ntag", 64'(network_data_tag_out), 64'({exp_tag, word}));
            network_ACK_in = 1'b1;
            tick();
            network_ACK_in = 1'b0;
            exp_tag = exp_tag + 8'd1;
        end

        // RX tag walk through 0xFF -> 0x00
        exp_tag = 8'h01;
        for (int i = 0; i < 256; i++) begin
            word                  = 32'(i) ^ 32'hA5A50000;
            network_data_tag_in   = {exp_tag, word};
            network_data_ready_in = 1'b1;
            tick();
            network_data_ready_in = 1'b0;
            $display("rx tag %02h data %08h", exp_tag, word);
            check("rxwrap.hdr", 64'(host_data_ready_out), 64'd1);
            check("rxwrap.host", 64'(host_data_out), 64'(word));
            exp_tag = exp_tag + 8'd1;
        end

        // Reset while waiting for ACK abandons the word
        data_parity_in       = 33'h1_00000001;
        data_parity_ready_in = 1'b1;
        tick();
        data_parity_ready_in = 1'b0;
        check("pre_rst.ntag", 64'(network_data_tag_out), 64'h02_00000001);
        reset = 1'b1;
        tick();
        $display("reset in TX_WAIT_ACK");
        check_all_zero("midrst");
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (network_data_ready_out) pulses++;
        end
        check("postrst.noretx", 64'(pulses), 64'd0);

        data_parity_in       = 33'h1_00000001;
        data_parity_ready_in = 1'b1;
        network_data_tag_in   = 40'h00_00000055;
        network_data_ready_in = 1'b1;
        tick();
        data_parity_ready_in  = 1'b0;
        network_data_ready_in = 1'b0;
        $display("concurrent tx/rx after reset");
        check("postrst.ntag", 64'(network_data_tag_out), 64'h00_00000001);
        check("postrst.hdr", 64'(host_data_ready_out), 64'd1);
        check("postrst.host", 64'(host_data_out), 64'h00000055);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
